// File: rtl/tx_pkg.sv
// tx_pkg: shared TX pacer types, length limits, lane width and saturating/clamp helpers.
package tx_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY, ST_GAP} tx_state_e;
   localparam int MIN_LEN_DEF = 64;
   localparam int MAX_LEN_DEF = 1518;
   localparam int XGMII_BYTES_PER_CLK = 8;
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? '1 : s[31:0];
   endfunction
   function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] lo,
                                             input logic [15:0] hi);
      return len < lo ? lo : len > hi ? hi : len;
   endfunction
   // Idle bytes rounded up to whole lane words, computed in 33 bits so 2^32-1 cannot wrap;
   // a zero gap still costs one cycle so GAP always has something to count.
   function automatic logic [31:0] gap_cycles(input logic [31:0] ifg, input int bpc);
      logic [32:0] g;
      g = ({1'b0, ifg} + 33'(bpc - 1)) / 33'(bpc);
      return g == '0 ? 32'd1 : g[31:0];
   endfunction
endpackage

// File: rtl/tx_stat_window.sv
// tx_stat_window: lifetime frame counter plus per-window frame/byte rates.
//  clk_i, rst_i     clock, async active-high reset
//  done_i, bytes_i  one completed frame and its length this cycle
//  frame_count_o    saturating lifetime frame count
//  pps_o, bps_o     frames / bytes completed in the last full window of CLK_HZ cycles
module tx_stat_window import tx_pkg::*; #(
   parameter int unsigned CLK_HZ = 156_250_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        done_i,
   input  logic [15:0] bytes_i,
   output logic [31:0] frame_count_o,
   output logic [31:0] pps_o,
   output logic [31:0] bps_o
);
   localparam int unsigned WW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
   logic [WW-1:0] win_q;
   logic [31:0] count_q, pps_acc_q, byte_acc_q, pps_q, bps_q, pps_d, bytes_d;
   logic wrap;
   assign wrap = win_q == WW'(CLK_HZ - 1);
   // A frame finishing on the wrap cycle is folded in before publishing, so it lands in the closing window.
   assign pps_d = sat_add(pps_acc_q, {31'b0, done_i});
   assign bytes_d = sat_add(byte_acc_q, done_i ? {16'b0, bytes_i} : 32'b0);
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         win_q <= '0;
         count_q <= '0;
         pps_acc_q <= '0;
         byte_acc_q <= '0;
         pps_q <= '0;
         bps_q <= '0;
      end else begin
         win_q <= wrap ? '0 : win_q + 1'b1;
         count_q <= sat_add(count_q, {31'b0, done_i});
         pps_acc_q <= wrap ? '0 : pps_d;
         byte_acc_q <= wrap ? '0 : bytes_d;
         if (wrap) begin
            pps_q <= pps_d;
            bps_q <= bytes_d;
         end
      end
   assign frame_count_o = count_q;
   assign pps_o = pps_q;
   assign bps_o = bps_q;
endmodule

// File: rtl/tx_frame_pacer.sv
// tx_frame_pacer: paces XGMII TX frame starts, latches length/gap, keeps per-port statistics.
//  sys_clk_i, sys_rst_i           clock, async active-high reset
//  tx_enable_i, tx_frame_len_i,
//  tx_inter_frame_gap_i           register inputs, sampled only when a frame is latched
//  gen_req_o/gen_ack_i            start handshake with the frame generator
//  gen_frame_len_o                clamped length of the current frame
//  gen_done_i                     generator finished the frame
//  busy_o                         any state but IDLE
//  tx_frame_count_o, tx_pps_o,
//  tx_throughput_o                statistics from tx_stat_window
module tx_frame_pacer import tx_pkg::*; #(
   parameter int unsigned CLK_HZ = 156_250_000,
   parameter int MIN_LEN = MIN_LEN_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int BYTES_PER_CLK = XGMII_BYTES_PER_CLK
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_i,
   input  logic        tx_enable_i,
   input  logic [15:0] tx_frame_len_i,
   input  logic [31:0] tx_inter_frame_gap_i,
   output logic        gen_req_o,
   input  logic        gen_ack_i,
   output logic [15:0] gen_frame_len_o,
   input  logic        gen_done_i,
   output logic        busy_o,
   output logic [31:0] tx_frame_count_o,
   output logic [31:0] tx_pps_o,
   output logic [31:0] tx_throughput_o
);
   tx_state_e state_q;
   logic [15:0] len_q, len_d;
   logic [31:0] gap_q, gap_d, cnt_q;
   logic req_q, busy_q, frame_done;
   assign len_d = clamp_len(tx_frame_len_i, 16'(MIN_LEN), 16'(MAX_LEN));
   assign gap_d = gap_cycles(tx_inter_frame_gap_i, BYTES_PER_CLK);
   assign frame_done = state_q == ST_BUSY && gen_done_i;
   always_ff @(posedge sys_clk_i or posedge sys_rst_i)
      if (sys_rst_i) begin
         state_q <= ST_IDLE;
         req_q <= 1'b0;
         busy_q <= 1'b0;
         len_q <= '0;
         gap_q <= '0;
         cnt_q <= '0;
      end else
         case (state_q)
            ST_IDLE:
               if (tx_enable_i) begin
                  state_q <= ST_REQ;
                  req_q <= 1'b1;
                  busy_q <= 1'b1;
                  len_q <= len_d;
                  gap_q <= gap_d;
               end
            // An ack racing a disable wins: the generator has already committed to the frame.
            ST_REQ:
               if (gen_ack_i) begin
                  state_q <= ST_BUSY;
                  req_q <= 1'b0;
               end else if (!tx_enable_i) begin
                  state_q <= ST_IDLE;
                  req_q <= 1'b0;
                  busy_q <= 1'b0;
               end
            ST_BUSY:
               if (gen_done_i) begin
                  state_q <= ST_GAP;
                  cnt_q <= gap_q;
               end
            // Leaving on cnt_q==1 makes the next gen_req rise exactly gap_q cycles after gen_done.
            ST_GAP:
               if (cnt_q > 32'd1) cnt_q <= cnt_q - 32'd1;
               else if (tx_enable_i) begin
                  state_q <= ST_REQ;
                  req_q <= 1'b1;
                  len_q <= len_d;
                  gap_q <= gap_d;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q <= 1'b0;
               end
            default: state_q <= ST_IDLE;
         endcase
   tx_stat_window #(.CLK_HZ(CLK_HZ)) u_win (
      .clk_i(sys_clk_i),
      .rst_i(sys_rst_i),
      .done_i(frame_done),
      .bytes_i(len_q),
      .frame_count_o(tx_frame_count_o),
      .pps_o(tx_pps_o),
      .bps_o(tx_throughput_o)
   );
   assign gen_req_o = req_q;
   assign busy_o = busy_q;
   assign gen_frame_len_o = len_q;
endmodule

// File: tb/tb_tx_frame_pacer.sv
// tb_tx_frame_pacer: directed plus randomized frames against a behavioural pacing/statistics model.
module tb_tx_frame_pacer;
   localparam int unsigned CLK_HZ = 1000;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, ack = 1'b0, done = 1'b0;
   logic [15:0] flen = '0;
   logic [31:0] ifg = '0;
   logic req, busy;
   logic [15:0] glen;
   logic [31:0] cnt, pps, thr;
   int nvec = 0, nerr = 0;
   longint cyc = 0, base = 0, cur_len = 0;
   longint done_e[$], done_len[$];
   always #5 clk = ~clk;
   tx_frame_pacer #(.CLK_HZ(CLK_HZ)) dut (
      .sys_clk_i(clk), .sys_rst_i(rst), .tx_enable_i(en), .tx_frame_len_i(flen),
      .tx_inter_frame_gap_i(ifg), .gen_req_o(req), .gen_ack_i(ack), .gen_frame_len_o(glen),
      .gen_done_i(done), .busy_o(busy), .tx_frame_count_o(cnt), .tx_pps_o(pps),
      .tx_throughput_o(thr)
   );
   // Edge numbers count from reset release; edge n belongs to window (n-1)/CLK_HZ.
   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else begin
         cyc <= cyc + 1;
         if (done) begin
            done_e.push_back(cyc + 1);
            done_len.push_back(cur_len);
         end
      end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic longint m_len(input longint l);
      return l < 64 ? 64 : l > 1518 ? 1518 : l;
   endfunction
   function automatic longint m_gap(input longint i);
      longint g = (i + 7) / 8;
      return g == 0 ? 1 : g;
   endfunction
   function automatic longint exp_count();
      longint c = base + longint'(done_e.size());
      return c > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : c;
   endfunction
   task automatic check_win();
      longint w = cyc / CLK_HZ - 1, p = 0, b = 0;
      foreach (done_e[i])
         if ((done_e[i] - 1) / CLK_HZ == w) begin
            p++;
            b += done_len[i];
         end
      chk("tx_pps", 64'(pps), 64'(p));
      chk("tx_throughput", 64'(thr), 64'(b));
   endtask
   // Entered at a negedge; returns at the negedge where the following gen_req is seen (or IDLE).
   task automatic do_frame(input int ack_dly, input int busy_dly, input longint exp_len,
                           input longint exp_gap, input int new_len, input int new_ifg,
                           input bit drop_en);
      int n = 0;
      while (!req && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("req_rise", 64'(req), 64'd1);
      chk("frame_len", 64'(glen), 64'(exp_len));
      cur_len = exp_len;
      repeat (ack_dly) @(negedge clk);
      chk("req_held", 64'(req), 64'd1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("req_drop", 64'(req), 64'd0);
      flen = 16'(new_len);
      ifg = 32'(new_ifg);
      if (drop_en) en = 1'b0;
      if (busy_dly < 0) while ((cyc + 1) % CLK_HZ != 0) @(negedge clk);
      else repeat (busy_dly - 1) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("len_stable", 64'(glen), 64'(exp_len));
      if (!drop_en) begin
         n = 0;
         while (!req && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("gap_cycles", 64'(n), 64'(exp_gap));
      end else begin
         repeat (exp_gap - 1) @(negedge clk);
         chk("busy_in_gap", 64'(busy), 64'd1);
         @(negedge clk);
         chk("busy_idle", 64'(busy), 64'd0);
         repeat (10) @(negedge clk);
         chk("no_req_after_drop", 64'(req), 64'd0);
      end
   endtask
   initial begin
      longint cl, cg, nl, ni;
      int n;
      repeat (3) @(negedge clk);
      chk("rst_req", 64'(req), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_len", 64'(glen), 64'd0);
      chk("rst_count", 64'(cnt), 64'd0);
      chk("rst_pps", 64'(pps), 64'd0);
      chk("rst_thr", 64'(thr), 64'd0);
      rst = 1'b0;
      flen = 16'd64;
      ifg = 32'd12;
      en = 1'b1;
      do_frame(0, 8, 64, 2, 64, 12, 0);
      do_frame(0, 8, 64, 2, 20, 0, 0);
      do_frame(1, 5, 64, 1, 9000, 100, 0);
      cl = 1518;
      cg = 13;
      for (int i = 0; i < 8; i++) begin
         nl = longint'($urandom_range(0, 3000));
         ni = longint'($urandom_range(0, 200));
         do_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)), cl, cg, int'(nl),
                  int'(ni), 0);
         cl = m_len(nl);
         cg = m_gap(ni);
      end
      do_frame(0, 4, cl, cg, 64, 8, 1);
      chk("count_after_busy_drop", 64'(cnt), 64'(exp_count()));
      flen = 16'd700;
      ifg = 32'd0;
      en = 1'b1;
      n = 0;
      while (!req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_before_withdraw", 64'(req), 64'd1);
      chk("withdraw_len", 64'(glen), 64'd700);
      en = 1'b0;
      @(negedge clk);
      chk("withdraw_req", 64'(req), 64'd0);
      chk("withdraw_busy", 64'(busy), 64'd0);
      chk("withdraw_count", 64'(cnt), 64'(exp_count()));
      for (int k = 0; k < 3000 && cyc < 1005; k++) @(negedge clk);
      check_win();
      flen = 16'd64;
      ifg = 32'd8;
      en = 1'b1;
      for (int k = 0; k < 300 && cyc < 1900; k++) do_frame(0, 8, 64, 1, 64, 8, 0);
      do_frame(0, -1, 64, 1, 64, 8, 0);
      do_frame(0, 8, 64, 1, 64, 8, 0);
      check_win();
      for (int k = 0; k < 300 && cyc < 3005; k++) do_frame(0, 8, 64, 1, 64, 8, 0);
      check_win();
      chk("steady_pps", 64'(pps), 64'd100);
      chk("steady_thr", 64'(thr), 64'd6400);
      force dut.u_win.count_q = 32'hFFFF_FFFE;
      base = 64'hFFFF_FFFE - longint'(done_e.size());
      #1 release dut.u_win.count_q;
      for (int k = 0; k < 3; k++) begin
         do_frame(0, 8, 64, 1, 64, 8, 0);
         chk("count_sat", 64'(cnt), 64'(exp_count()));
      end
      chk("count_at_max", 64'(cnt), 64'hFFFF_FFFF);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("busy_before_rst", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_req", 64'(req), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_len", 64'(glen), 64'd0);
      chk("midrst_count", 64'(cnt), 64'd0);
      chk("midrst_pps", 64'(pps), 64'd0);
      chk("midrst_thr", 64'(thr), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
